// File: rtl/dec_entry.sv
// Decimal operand entry: keyed BCD digits accumulate into binary operands A and B.
// Define DEBOUNCE_EN to add a DEB_CYCLES stable-time filter on every pushbutton.
module dec_entry #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned MAX_DIGITS = 2
`ifdef DEBOUNCE_EN
    ,
    parameter int unsigned DEB_CYCLES = 500000
`endif
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [3:0]              DIGIT,
    input  logic                    KEY_DIG,
    input  logic                    KEY_NEXT,
    input  logic                    KEY_CLR,
    output logic [WIDTH-1:0]        OP_A,
    output logic [WIDTH-1:0]        OP_B,
    output logic                    OP_VALID,
    output logic [4*MAX_DIGITS-1:0] ENTRY_BCD,
    output logic                    ERR,
    output logic [1:0]              STATE
);

    localparam int unsigned NKeys = 3;
    localparam int unsigned KDig  = 0;
    localparam int unsigned KNext = 1;
    localparam int unsigned KClr  = 2;
    localparam int unsigned CW    = WIDTH + 4;
    localparam int unsigned EW    = 4 * MAX_DIGITS;
    localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MaxOp = CW'({WIDTH{1'b1}});

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Key conditioning: 2-FF synchroniser, optional filter, falling-edge detect
    logic [NKeys-1:0] keys_n;
    logic [NKeys-1:0] sync1_q, sync2_q, prev_q;
    logic [NKeys-1:0] level;
    logic [NKeys-1:0] ev;
    logic             ev_clr, ev_next, ev_dig;

    assign keys_n = {KEY_CLR, KEY_NEXT, KEY_DIG};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= keys_n;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [NKeys-1:0] filt_q;
    logic [DebW-1:0]  deb_cnt_q [NKeys];

    // Filtered level follows the synced level only after DEB_CYCLES consecutive disagreeing clocks
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            filt_q <= '1;
            for (int i = 0; i < int'(NKeys); i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NKeys); i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
                    filt_q[i]    <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign ev      = prev_q & ~level;
    assign ev_clr  = ev[KClr];
    assign ev_next = ev[KNext] & ~ev[KClr];
    assign ev_dig  = ev[KDig] & ~ev[KNext] & ~ev[KClr];

    // Entry state and registered outputs
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [EW-1:0]        entry_q, entry_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic                 valid_q, valid_d;
    logic [CW-1:0]        cand;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_A;
            acc_q   <= '0;
            cnt_q   <= '0;
            entry_q <= '0;
            err_q   <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
            err_q   <= err_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        err_d   = err_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        valid_d = valid_q;
        // Full-width candidate so an overflowing entry is caught before truncation
        cand    = CW'(acc_q) * CW'(10) + CW'(DIGIT);

        if (ev_clr) begin
            state_d = S_A;
            acc_d   = '0;
            cnt_d   = '0;
            entry_d = '0;
            err_d   = 1'b0;
            op_a_d  = '0;
            op_b_d  = '0;
            valid_d = 1'b0;
        end else if (ev_next) begin
            case (state_q)
                S_A: begin
                    op_a_d  = acc_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    entry_d = '0;
                    err_d   = 1'b0;
                    state_d = S_B;
                end
                S_B: begin
                    op_b_d  = acc_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    entry_d = '0;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end else if (ev_dig && (state_q == S_A || state_q == S_B)) begin
            if (DIGIT > 4'd9 || cnt_q == CntW'(MAX_DIGITS) || cand > MaxOp) begin
                err_d = 1'b1;
            end else begin
                acc_d   = WIDTH'(cand);
                cnt_d   = cnt_q + CntW'(1);
                entry_d = (entry_q << 4) | EW'(DIGIT);
                err_d   = 1'b0;
            end
        end
    end

    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign OP_VALID  = valid_q;
    assign ENTRY_BCD = entry_q;
    assign ERR       = err_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_dec_entry.sv
// Scoreboard bench for dec_entry: key presses queue expected output snapshots,
// a negedge monitor compares them on their due cycle.
module tb_dec_entry;

`ifdef DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT  = 3 + DEB;
    localparam int HOLD = DEB + 4;
    localparam int GAP  = DEB + 8;

    localparam logic [2:0] K_DIG = 3'b001;
    localparam logic [2:0] K_NXT = 3'b010;
    localparam logic [2:0] K_CLR = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       key_dig = 1'b1;
    logic       key_next = 1'b1;
    logic       key_clr = 1'b1;
    logic [4:0] op_a, op_b;
    logic       op_valid;
    logic [7:0] entry_bcd;
    logic       err;
    logic [1:0] state;

`ifdef DEBOUNCE_EN
    dec_entry #(.DEB_CYCLES(DEB)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .DIGIT     (digit),
        .KEY_DIG   (key_dig),
        .KEY_NEXT  (key_next),
        .KEY_CLR   (key_clr),
        .OP_A      (op_a),
        .OP_B      (op_b),
        .OP_VALID  (op_valid),
        .ENTRY_BCD (entry_bcd),
        .ERR       (err),
        .STATE     (state)
    );
`else
    dec_entry dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .DIGIT     (digit),
        .KEY_DIG   (key_dig),
        .KEY_NEXT  (key_next),
        .KEY_CLR   (key_clr),
        .OP_A      (op_a),
        .OP_B      (op_b),
        .OP_VALID  (op_valid),
        .ENTRY_BCD (entry_bcd),
        .ERR       (err),
        .STATE     (state)
    );
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         tag;
        logic [4:0] a;
        logic [4:0] b;
        logic       v;
        logic [7:0] e;
        logic       r;
        logic [1:0] s;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Last expected snapshot, used to check that nothing moves before the latency expires
    logic [4:0] p_a = 5'd0, p_b = 5'd0;
    logic       p_v = 1'b0, p_r = 1'b0;
    logic [7:0] p_e = 8'h00;
    logic [1:0] p_s = 2'b00;

    function automatic void push(input int due, input int tag, input logic [4:0] a,
                                 input logic [4:0] b, input logic v, input logic [7:0] e,
                                 input logic r, input logic [1:0] s);
        exp_t x;
        x.due = due; x.tag = tag; x.a = a; x.b = b; x.v = v; x.e = e; x.r = r; x.s = s;
        sb.push_back(x);
    endfunction

    function automatic void chk(input int tag, input string f, input logic [7:0] act,
                                input logic [7:0] expv);
        n_chk++;
        if (act !== expv)
            $display("FAIL tag=%0d %s got=%0h expected=%0h (cycle %0d)", tag, f, act, expv, cyc);
        else
            n_pass++;
    endfunction

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            if (cur.due != cyc) begin
                n_chk++;
                $display("FAIL tag=%0d late_check got_cycle=%0d expected_cycle=%0d", cur.tag, cyc, cur.due);
            end else begin
                chk(cur.tag, "OP_A",      8'(op_a),      8'(cur.a));
                chk(cur.tag, "OP_B",      8'(op_b),      8'(cur.b));
                chk(cur.tag, "OP_VALID",  8'(op_valid),  8'(cur.v));
                chk(cur.tag, "ENTRY_BCD", entry_bcd,     cur.e);
                chk(cur.tag, "ERR",       8'(err),       8'(cur.r));
                chk(cur.tag, "STATE",     8'(state),     8'(cur.s));
            end
        end
    end

    task automatic key(input logic [2:0] k, input logic [3:0] d, input int hold, input int tag,
                       input logic [4:0] ea, input logic [4:0] eb, input logic ev,
                       input logic [7:0] ee, input logic er, input logic [1:0] es);
        int t;
        @(posedge clk); #1;
        digit    = d;
        key_dig  = ~k[0];
        key_next = ~k[1];
        key_clr  = ~k[2];
        t = cyc;
        push(t + LAT - 1, tag, p_a, p_b, p_v, p_e, p_r, p_s);
        push(t + LAT, tag, ea, eb, ev, ee, er, es);
        push(t + hold + GAP - 2, tag, ea, eb, ev, ee, er, es);
        p_a = ea; p_b = eb; p_v = ev; p_e = ee; p_r = er; p_s = es;
        repeat (hold) @(posedge clk);
        #1;
        key_dig = 1'b1; key_next = 1'b1; key_clr = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic do_reset(input int tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        push(cyc, tag, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(cyc, tag, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 2'b00);
        p_a = 5'd0; p_b = 5'd0; p_v = 1'b0; p_e = 8'h00; p_r = 1'b0; p_s = 2'b00;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset(1);

        // A=27, B=14, DONE, digit ignored in DONE, back to S_A
        key(K_DIG, 4'd2, HOLD, 10, 5'd0,  5'd0,  1'b0, 8'h02, 1'b0, 2'b00);
        key(K_DIG, 4'd7, HOLD, 11, 5'd0,  5'd0,  1'b0, 8'h27, 1'b0, 2'b00);
        key(K_NXT, 4'd7, HOLD, 12, 5'd27, 5'd0,  1'b0, 8'h00, 1'b0, 2'b01);
        key(K_DIG, 4'd1, HOLD, 13, 5'd27, 5'd0,  1'b0, 8'h01, 1'b0, 2'b01);
        key(K_DIG, 4'd4, HOLD, 14, 5'd27, 5'd0,  1'b0, 8'h14, 1'b0, 2'b01);
        key(K_NXT, 4'd4, HOLD, 15, 5'd27, 5'd14, 1'b1, 8'h00, 1'b0, 2'b10);
        key(K_DIG, 4'd3, HOLD, 16, 5'd27, 5'd14, 1'b1, 8'h00, 1'b0, 2'b10);
        key(K_NXT, 4'd3, HOLD, 17, 5'd27, 5'd14, 1'b0, 8'h00, 1'b0, 2'b00);

        // Range overflow: 35 rejected, 31 accepted as the maximum value
        key(K_DIG, 4'd3, HOLD, 20, 5'd27, 5'd14, 1'b0, 8'h03, 1'b0, 2'b00);
        key(K_DIG, 4'd5, HOLD, 21, 5'd27, 5'd14, 1'b0, 8'h03, 1'b1, 2'b00);
        key(K_DIG, 4'd1, HOLD, 22, 5'd27, 5'd14, 1'b0, 8'h31, 1'b0, 2'b00);
        key(K_NXT, 4'd1, HOLD, 23, 5'd31, 5'd14, 1'b0, 8'h00, 1'b0, 2'b01);

        // Non-BCD digit and too many digits, in S_B
        key(K_DIG, 4'd12, HOLD, 30, 5'd31, 5'd14, 1'b0, 8'h00, 1'b1, 2'b01);
        key(K_DIG, 4'd1,  HOLD, 31, 5'd31, 5'd14, 1'b0, 8'h01, 1'b0, 2'b01);
        key(K_DIG, 4'd0,  HOLD, 32, 5'd31, 5'd14, 1'b0, 8'h10, 1'b0, 2'b01);
        key(K_DIG, 4'd0,  HOLD, 33, 5'd31, 5'd14, 1'b0, 8'h10, 1'b1, 2'b01);
        key(K_NXT, 4'd0,  HOLD, 34, 5'd31, 5'd10, 1'b1, 8'h00, 1'b0, 2'b10);
        key(K_NXT, 4'd0,  HOLD, 35, 5'd31, 5'd10, 1'b0, 8'h00, 1'b0, 2'b00);

        // CLR beats NEXT; long hold gives exactly one digit
        key(K_DIG, 4'd5, HOLD, 40, 5'd31, 5'd10, 1'b0, 8'h05, 1'b0, 2'b00);
        key(K_NXT, 4'd5, HOLD, 41, 5'd5,  5'd10, 1'b0, 8'h00, 1'b0, 2'b01);
        key(K_DIG, 4'd9, HOLD, 42, 5'd5,  5'd10, 1'b0, 8'h09, 1'b0, 2'b01);
        key(K_CLR | K_NXT, 4'd9, HOLD, 43, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 2'b00);
        key(K_DIG, 4'd6, 20,   44, 5'd0,  5'd0,  1'b0, 8'h06, 1'b0, 2'b00);

        // Async reset in S_B with acc=7
        key(K_NXT, 4'd6, HOLD, 50, 5'd6,  5'd0,  1'b0, 8'h00, 1'b0, 2'b01);
        key(K_DIG, 4'd7, HOLD, 51, 5'd6,  5'd0,  1'b0, 8'h07, 1'b0, 2'b01);
        do_reset(52);

        // CLR beats DIG, NEXT beats DIG
        key(K_DIG, 4'd8, HOLD, 53, 5'd0, 5'd0, 1'b0, 8'h08, 1'b0, 2'b00);
        key(K_CLR | K_DIG, 4'd3, HOLD, 54, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 2'b00);
        key(K_DIG, 4'd2, HOLD, 55, 5'd0, 5'd0, 1'b0, 8'h02, 1'b0, 2'b00);
        key(K_NXT | K_DIG, 4'd4, HOLD, 56, 5'd2, 5'd0, 1'b0, 8'h00, 1'b0, 2'b01);

`ifdef DEBOUNCE_EN
        // Short glitch is filtered; an 8-cycle press lands after 3+DEB cycles
        begin
            int t;
            @(posedge clk); #1;
            digit = 4'd5;
            key_dig = 1'b0;
            t = cyc;
            push(t + LAT + 4, 60, 5'd2, 5'd0, 1'b0, 8'h00, 1'b0, 2'b01);
            repeat (2) @(posedge clk);
            #1;
            key_dig = 1'b1;
            repeat (GAP + 4) @(posedge clk);
        end
        key(K_DIG, 4'd5, 8, 61, 5'd2, 5'd0, 1'b0, 8'h05, 1'b0, 2'b01);
`endif

        repeat (5) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL leftover_checks got=%0d expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
